// File: rtl/dec138_arbiter_if.sv
// Request/decoder-control bundle between bus requesters and dec138_arbiter.
// The master side raises req/lock; the slave (arbiter) drives the decoder controls and acks.
interface dec138_arbiter_if;
  logic [7:0] req;
  logic [7:0] lock;
  logic [2:0] sel;
  logic       g1;
  logic       g2a_n;
  logic       g2b_n;
  logic [7:0] ack;
  logic       busy;
  logic [2:0] grant_idx;

  modport master (
    output req, lock,
    input  sel, g1, g2a_n, g2b_n, ack, busy, grant_idx
  );

  modport slave (
    input  req, lock,
    output sel, g1, g2a_n, g2b_n, ack, busy, grant_idx
  );
endinterface

// File: rtl/dec138_arbiter.sv
// Round-robin arbiter and strobe sequencer that shares one 74S138 decoder among 8 requesters.
// Optional locked regrant of the current winner is enabled by defining DEC_ARB_LOCK_EN.
module dec138_arbiter #(
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input logic            clk,
  input logic            reset,
  dec138_arbiter_if.slave bus
);

  if (STROBE_CYCLES < 1 || STROBE_CYCLES > 16 || HOLD_CYCLES < 1 || HOLD_CYCLES > 16) begin : g_param_check
    $fatal(1, "dec138_arbiter: STROBE_CYCLES and HOLD_CYCLES must be in 1..16");
  end

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t     state_q;
  logic [4:0] cnt_q;
  logic [2:0] ptr_q;
  logic [2:0] sel_q;
  logic [2:0] grant_q;
  logic       g1_q;
  logic       g2_n_q;
  logic [7:0] ack_q;
  logic       busy_q;

  logic [2:0] win_d;
  logic [2:0] idx;
  logic       found;
  logic       req_any;
  logic       keep_d;

  assign req_any = |bus.req;

  // First requester at or after ptr+1, wrapping; k=8 lands back on ptr itself.
  always_comb begin
    win_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win_d = idx;
      end
    end
  end

`ifdef DEC_ARB_LOCK_EN
  assign keep_d = bus.lock[grant_q] & bus.req[grant_q];
`else
  logic unused_lock;
  assign unused_lock = ^bus.lock;
  assign keep_d      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 3'd7;
      sel_q   <= '0;
      grant_q <= '0;
      g1_q    <= 1'b0;
      g2_n_q  <= 1'b1;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (req_any) begin
            ptr_q   <= win_d;
            grant_q <= win_d;
            sel_q   <= win_d;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          state_q <= STROBE;
          g1_q    <= 1'b1;
          g2_n_q  <= 1'b0;
          cnt_q   <= 5'(STROBE_CYCLES);
          if (STROBE_CYCLES == 1) ack_q <= 8'b1 << grant_q;
        end
        STROBE: begin
          if (cnt_q == 5'd1) begin
            state_q <= HOLD;
            g1_q    <= 1'b0;
            g2_n_q  <= 1'b1;
            cnt_q   <= 5'(HOLD_CYCLES);
          end else begin
            cnt_q <= cnt_q - 5'd1;
            // ack lands on the last strobe cycle, i.e. when the count reaches 1
            if (cnt_q == 5'd2) ack_q <= 8'b1 << grant_q;
          end
        end
        HOLD: begin
          if (cnt_q > 5'd1) begin
            cnt_q <= cnt_q - 5'd1;
          end else begin
            cnt_q <= '0;
            if (keep_d) begin
              state_q <= SETUP;
            end else if (req_any) begin
              ptr_q   <= win_d;
              grant_q <= win_d;
              sel_q   <= win_d;
              state_q <= SETUP;
            end else begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.g1        = g1_q;
  assign bus.g2a_n     = g2_n_q;
  assign bus.g2b_n     = g2_n_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.grant_idx = grant_q;

endmodule

// File: tb/tb_dec138_arbiter.sv
// Self-checking bench for dec138_arbiter: a transaction-phase model checked every cycle,
// plus directed scenarios with literal expectations on two parameterisations.
module tb_dec138_arbiter;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   cmp_en = 0;
  bit   saw_ack3_b = 0;
  int   obs[$];
  int   stamps[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dec138_arbiter_if if_a ();
  dec138_arbiter_if if_b ();

  dec138_arbiter dut_a (.clk(clk), .reset(rst_a), .bus(if_a));
  dec138_arbiter #(.STROBE_CYCLES(4), .HOLD_CYCLES(3)) dut_b (.clk(clk), .reset(rst_b), .bus(if_b));

  localparam int S_P[2] = '{2, 4};
  localparam int H_P[2] = '{1, 3};

  // Model: a transaction is a phase index t: 0 = setup, 1..S = strobe, S+1..S+H = hold.
  typedef struct {
    bit active;
    int t;
    int ptr;
    int grant;
  } m_t;

  m_t m[2];

  function automatic int rr(input logic [7:0] r, input int p);
    for (int k = 1; k <= 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
    return p;
  endfunction

  function automatic m_t step(input m_t s, input logic [7:0] r, input logic [7:0] l,
                              input logic rs, input int S, input int H);
    m_t n = s;
    if (rs) begin
      n.active = 0; n.t = 0; n.ptr = 7; n.grant = 0;
      return n;
    end
    if (!s.active || s.t == S + H) begin
`ifdef DEC_ARB_LOCK_EN
      if (s.active && l[s.grant] && r[s.grant]) begin
        n.t = 0;
        return n;
      end
`endif
      if (r != 0) begin
        n.active = 1; n.t = 0; n.ptr = rr(r, s.ptr); n.grant = n.ptr;
      end else begin
        n.active = 0; n.t = 0;
      end
    end else begin
      n.t = s.t + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m[0] <= step(m[0], if_a.req, if_a.lock, rst_a, S_P[0], H_P[0]);
    m[1] <= step(m[1], if_b.req, if_b.lock, rst_b, S_P[1], H_P[1]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [7:0] a);
    for (int i = 0; i < 8; i++) if (a[i]) return i;
    return -1;
  endfunction

  task automatic cmp_inst(input int i, input logic [2:0] sel, input logic g1, input logic g2a_n,
                          input logic g2b_n, input logic [7:0] ack, input logic busy,
                          input logic [2:0] gidx);
    bit   e_g1;
    logic [7:0] e_ack;
    e_g1  = m[i].active && m[i].t >= 1 && m[i].t <= S_P[i];
    e_ack = (m[i].active && m[i].t == S_P[i]) ? (8'b1 << m[i].grant) : 8'h00;
    chk($sformatf("inst%0d.g1", i), 32'(g1), 32'(e_g1));
    chk($sformatf("inst%0d.g2a_n", i), 32'(g2a_n), 32'(!e_g1));
    chk($sformatf("inst%0d.g2b_n", i), 32'(g2b_n), 32'(!e_g1));
    chk($sformatf("inst%0d.ack", i), 32'(ack), 32'(e_ack));
    chk($sformatf("inst%0d.busy", i), 32'(busy), 32'(m[i].active));
    chk($sformatf("inst%0d.sel", i), 32'(sel), 32'(m[i].grant));
    chk($sformatf("inst%0d.grant_idx", i), 32'(gidx), 32'(m[i].grant));
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_inst(0, if_a.sel, if_a.g1, if_a.g2a_n, if_a.g2b_n, if_a.ack, if_a.busy, if_a.grant_idx);
      cmp_inst(1, if_b.sel, if_b.g1, if_b.g2a_n, if_b.g2b_n, if_b.ack, if_b.busy, if_b.grant_idx);
      if (if_b.ack[3]) saw_ack3_b = 1;
    end
  end

  task automatic collect(input int n, input int budget, input int inst);
    logic [7:0] a;
    obs.delete();
    stamps.delete();
    while (obs.size() < n && budget > 0) begin
      @(negedge clk);
      budget--;
      a = (inst == 0) ? if_a.ack : if_b.ack;
      if (a != 8'h00) begin
        chk("ack_onehot", 32'($countones(a)), 32'd1);
        obs.push_back(onehot_idx(a));
        stamps.push_back(cyc);
      end
    end
    if (obs.size() < n) chk("ack_timeout", 32'(obs.size()), 32'(n));
  endtask

  task automatic pulse_reset_a();
    rst_a = 1;
    @(negedge clk);
    rst_a = 0;
  endtask

  initial begin
    int exp_lock[4];
    if_a.req = 0; if_a.lock = 0; if_b.req = 0; if_b.lock = 0;
    rst_a = 1; rst_b = 1;
    repeat (2) @(negedge clk);
    cmp_en = 1;
    rst_a = 0; rst_b = 0;

    // idle with no requests
    repeat (20) @(negedge clk);
    chk("idle_busy", 32'(if_a.busy), 32'd0);
    chk("idle_g2a_n", 32'(if_a.g2a_n), 32'd1);

    // single request from requester 5
    if_a.req = 8'h20;
    @(negedge clk);
    if_a.req = 8'h00;
    chk("single_setup_busy", 32'(if_a.busy), 32'd1);
    chk("single_setup_g1", 32'(if_a.g1), 32'd0);
    chk("single_setup_sel", 32'(if_a.sel), 32'd5);
    @(negedge clk);
    chk("single_strobe1_g1", 32'(if_a.g1), 32'd1);
    chk("single_strobe1_g2a_n", 32'(if_a.g2a_n), 32'd0);
    chk("single_strobe1_ack", 32'(if_a.ack), 32'h00);
    @(negedge clk);
    chk("single_strobe2_ack", 32'(if_a.ack), 32'h20);
    chk("single_strobe2_sel", 32'(if_a.sel), 32'd5);
    @(negedge clk);
    chk("single_hold_g1", 32'(if_a.g1), 32'd0);
    chk("single_hold_busy", 32'(if_a.busy), 32'd1);
    @(negedge clk);
    chk("single_idle_busy", 32'(if_a.busy), 32'd0);

    // all requesting: strict rotation, back-to-back
    pulse_reset_a();
    if_a.req = 8'hFF;
    collect(9, 100, 0);
    for (int i = 0; i < 9; i++) chk($sformatf("rot_order[%0d]", i), 32'(obs[i]), 32'(i % 8));
    chk("rot_period", 32'(stamps[1] - stamps[0]), 32'd4);
    chk("rot_period_wrap", 32'(stamps[8] - stamps[7]), 32'd4);

    // requesters 7 and 0 alternate once 7 has been served
    pulse_reset_a();
    if_a.req = 8'h80;
    collect(1, 20, 0);
    chk("alt_first", 32'(obs[0]), 32'd7);
    if_a.req = 8'h81;
    collect(4, 40, 0);
    chk("alt[0]", 32'(obs[0]), 32'd0);
    chk("alt[1]", 32'(obs[1]), 32'd7);
    chk("alt[2]", 32'(obs[2]), 32'd0);
    chk("alt[3]", 32'(obs[3]), 32'd7);
    if_a.req = 8'h00;
    repeat (6) @(negedge clk);

    // reset mid-strobe on the long-strobe instance
    if_b.req = 8'h08;
    @(negedge clk);
    if_b.req = 8'h00;
    chk("b_setup_sel", 32'(if_b.sel), 32'd3);
    @(negedge clk);
    @(negedge clk);
    chk("b_strobe2_g1", 32'(if_b.g1), 32'd1);
    rst_b = 1;
    @(negedge clk);
    chk("b_abort_g1", 32'(if_b.g1), 32'd0);
    chk("b_abort_g2a_n", 32'(if_b.g2a_n), 32'd1);
    chk("b_abort_busy", 32'(if_b.busy), 32'd0);
    chk("b_abort_ack", 32'(if_b.ack), 32'h00);
    rst_b = 0;
    if_b.req = 8'h18;
    @(negedge clk);
    if_b.req = 8'h00;
    chk("b_after_reset_grant", 32'(if_b.grant_idx), 32'd3);
    collect(1, 20, 1);
    chk("b_no_ack3_aborted", 32'(stamps[0] > 0 ? 1 : 0), 32'd1);
    repeat (6) @(negedge clk);

    // lock behaviour (regrant only when the feature is built in)
    pulse_reset_a();
    if_a.req = 8'h06;
    if_a.lock = 8'h02;
    collect(1, 20, 0);
    chk("lock_first", 32'(obs[0]), 32'd1);
`ifdef DEC_ARB_LOCK_EN
    exp_lock = '{1, 1, 2, 0};
`else
    exp_lock = '{2, 1, 2, 0};
`endif
    collect(2, 40, 0);
    chk("lock_seq[0]", 32'(obs[0]), 32'(exp_lock[0]));
    chk("lock_seq[1]", 32'(obs[1]), 32'(exp_lock[1]));
    if_a.lock = 8'h00;
    collect(1, 20, 0);
    chk("lock_after_drop", 32'(obs[0]), 32'(exp_lock[2]));
    if_a.req = 8'h00;
    repeat (10) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // The aborted requester-3 transaction must never have acked; the later grant to 3 is
  // checked separately, so this only watches the abort window.
  initial begin
    wait (rst_b === 1'b1 && cmp_en);
    @(negedge clk);
    chk("b_abort_no_ack3", 32'(saw_ack3_b), 32'd0);
  end

endmodule
